// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher round sequencer (one inverse round per clock) with its InvMixColumns datapath.
// Optional abort input is built when AES_INV_ABORT_EN is defined.

module inverse_mixcolumn (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Row r of each column: 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3], indices mod 4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign o_state[32*r+8*c +: 8] =
          mule(i_state[32*r+8*c +: 8]) ^
          mulb(i_state[32*((r+1)%4)+8*c +: 8]) ^
          muld(i_state[32*((r+2)%4)+8*c +: 8]) ^
          mul9(i_state[32*((r+3)%4)+8*c +: 8]);
    end
  end

endmodule

module aes_inv_round_ctrl #(
  parameter int unsigned NR       = 14,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AES_INV_ABORT_EN
  input  logic                abort,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_in,
  output logic [127:0]        sb_in,
  input  logic [127:0]        sb_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end
  if (NR >= (1 << RK_IDX_W)) begin : g_bad_rkw
    $error("aes_inv_round_ctrl: RK_IDX_W too narrow to hold NR");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  fsm_t                r_fsm;
  fsm_t                w_fsm_nxt;
  logic [127:0]        r_state;
  logic [127:0]        w_state_nxt;
  logic [RK_IDX_W-1:0] r_rnd;
  logic [RK_IDX_W-1:0] w_rnd_nxt;
  logic [127:0]        w_isr;
  logic [127:0]        w_ark;
  logic [127:0]        w_imc;

  // InvShiftRows is pure wiring: row r rotates right by r byte positions
  for (genvar r = 0; r < 4; r++) begin : g_isr_row
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
      assign w_isr[32*r+8*c +: 8] = r_state[32*r+8*((c-r+4)%4) +: 8];
    end
  end

  assign sb_in    = w_isr;
  assign w_ark    = sb_out ^ rk_in;
  assign out_data = r_state;

  inverse_mixcolumn u_imc (
    .i_state (w_ark),
    .o_state (w_imc)
  );

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    rk_idx      = RK_IDX_W'(NR);
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_nxt = in_data ^ rk_in;
          w_rnd_nxt   = RK_IDX_W'(NR - 1);
          w_fsm_nxt   = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_idx = r_rnd;
        if (r_rnd != '0) begin
          w_state_nxt = w_imc;
          w_rnd_nxt   = r_rnd - RK_IDX_W'(1);
        end else begin
          w_state_nxt = w_ark;
          w_fsm_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
`ifdef AES_INV_ABORT_EN
    // Abort overrides both round progress and a pending output handshake
    if (abort && r_fsm != S_IDLE) begin
      w_fsm_nxt   = S_IDLE;
      w_state_nxt = '0;
      w_rnd_nxt   = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_rnd   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
    end
  end

endmodule
